// File: rtl/fc2_result_collector.sv
// Collects FC2 logits per frame, picks the argmax class and tracks consecutive
// "eye closed" results for the drowsiness alarm, with frame timeout and protocol checks.
//
// state | meaning
// IDLE  | no frame in flight, waiting for the first pixel
// LOAD  | frame pixels streaming into the accelerator
// WAIT  | pixels done, collecting logit beats (timeout running)
// DONE  | result held on class_id until acknowledged
module fc2_result_collector #(
  parameter int NUM_CLASSES    = 2,
  parameter int CLOSE_CLASS    = 0,
  parameter int STREAK_THRESH  = 3,
  parameter int TIMEOUT_CYCLES = 300000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic                           valid_out_fc2,
  input  logic [31:0]                    data_out_fc2,
  input  logic                           result_ack,
  output logic                           class_valid,
  output logic [$clog2(NUM_CLASSES)-1:0] class_id,
  output logic [7:0]                     close_streak,
  output logic                           drowsy_alarm,
  output logic                           frame_timeout,
  output logic                           protocol_err,
  output logic [15:0]                    frame_count
);

  localparam int CW = $clog2(NUM_CLASSES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);
  localparam logic [CW-1:0] CLOSE_ID = CW'(CLOSE_CLASS);
  localparam logic [TW-1:0] TC_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    THRESH   = 8'(STREAK_THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic                 vin_q;
  logic [CW-1:0]        beat_idx;
  logic [TW-1:0]        tcnt;
  logic signed [31:0]   logits [NUM_CLASSES];

  logic                 vin_rise;
  logic                 vin_fall;
  logic                 last_beat;
  logic signed [31:0]   best_val;
  logic signed [31:0]   cand;
  logic [CW-1:0]        best_idx;
  logic [7:0]           streak_next;

  assign vin_rise  = valid_in & ~vin_q;
  assign vin_fall  = ~valid_in & vin_q;
  assign last_beat = valid_out_fc2 && (beat_idx == LAST_IDX);

  // The final logit is taken straight from the bus so the result lands on the same edge.
  always_comb begin
    best_idx = '0;
    best_val = logits[0];
    cand     = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      cand = (i == NUM_CLASSES - 1) ? $signed(data_out_fc2) : logits[i];
      if (cand > best_val) begin
        best_val = cand;
        best_idx = CW'(i);
      end
    end
  end

  always_comb begin
    streak_next = 8'd0;
    if (best_idx == CLOSE_ID)
      streak_next = (close_streak == 8'hFF) ? 8'hFF : close_streak + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vin_q         <= 1'b0;
      beat_idx      <= '0;
      tcnt          <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) logits[i] <= '0;
      class_valid   <= 1'b0;
      class_id      <= '0;
      close_streak  <= 8'd0;
      drowsy_alarm  <= 1'b0;
      frame_timeout <= 1'b0;
      protocol_err  <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      vin_q         <= valid_in;
      frame_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_out_fc2) protocol_err <= 1'b1;
          if (vin_rise) state <= LOAD;
        end
        LOAD: begin
          if (valid_out_fc2) protocol_err <= 1'b1;
          if (vin_fall) begin
            state    <= WAIT;
            beat_idx <= '0;
            tcnt     <= '0;
          end
        end
        WAIT: begin
          if (vin_rise) begin
            protocol_err <= 1'b1;
            beat_idx     <= '0;
            state        <= LOAD;
          end else if (last_beat) begin
            // Last beat beats a coincident timeout.
            logits[beat_idx] <= data_out_fc2;
            class_valid      <= 1'b1;
            class_id         <= best_idx;
            close_streak     <= streak_next;
            drowsy_alarm     <= (streak_next >= THRESH);
            frame_count      <= frame_count + 16'd1;
            state            <= DONE;
          end else if (tcnt == TC_LAST) begin
            frame_timeout <= 1'b1;
            close_streak  <= 8'd0;
            drowsy_alarm  <= 1'b0;
            beat_idx      <= '0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (valid_out_fc2) begin
              logits[beat_idx] <= data_out_fc2;
              beat_idx         <= beat_idx + CW'(1);
            end
          end
        end
        DONE: begin
          if (valid_out_fc2) protocol_err <= 1'b1;
          if (vin_rise) begin
            // A simultaneous ack makes the new frame legitimate.
            if (!result_ack) protocol_err <= 1'b1;
            class_valid <= 1'b0;
            state       <= LOAD;
          end else if (result_ack) begin
            class_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc2_result_collector.sv
// Directed bench for fc2_result_collector with hand-computed expectations.
module tb_fc2_result_collector;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        valid_out_fc2;
  logic [31:0] data_out_fc2;
  logic        result_ack;
  logic        class_valid;
  logic [0:0]  class_id;
  logic [7:0]  close_streak;
  logic        drowsy_alarm;
  logic        frame_timeout;
  logic        protocol_err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  fc2_result_collector #(
    .NUM_CLASSES(2), .CLOSE_CLASS(0), .STREAK_THRESH(3), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .valid_out_fc2(valid_out_fc2),
    .data_out_fc2(data_out_fc2), .result_ack(result_ack), .class_valid(class_valid),
    .class_id(class_id), .close_streak(close_streak), .drowsy_alarm(drowsy_alarm),
    .frame_timeout(frame_timeout), .protocol_err(protocol_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n);
    valid_in = 1'b1;
    repeat (n) tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [31:0] d);
    valid_out_fc2 = 1'b1;
    data_out_fc2  = d;
    tick();
    valid_out_fc2 = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] cid, input logic [31:0] streak,
                              input logic [31:0] alarm, input logic [31:0] cnt);
    check_val({tag, "_valid"}, 32'(class_valid), 32'd1);
    check_val({tag, "_class"}, 32'(class_id), cid);
    check_val({tag, "_streak"}, 32'(close_streak), streak);
    check_val({tag, "_alarm"}, 32'(drowsy_alarm), alarm);
    check_val({tag, "_count"}, 32'(frame_count), cnt);
  endtask

  initial begin
    int pulses;
    int first_k;
    rst_n = 1'b0; valid_in = 1'b0; valid_out_fc2 = 1'b0; data_out_fc2 = '0; result_ack = 1'b0;
    tick(); tick();
    check_val("rst_valid", 32'(class_valid), 32'd0);
    check_val("rst_count", 32'(frame_count), 32'd0);
    check_val("rst_perr", 32'(protocol_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single long frame: -5, +7 -> class 1
    pixels(884);
    check_val("f1_state_wait", 32'(dut.state), 32'd2);
    beat(-32'sd5);
    check_val("f1_not_yet", 32'(class_valid), 32'd0);
    beat(32'sd7);
    check_result("f1", 1, 0, 0, 1);
    check_val("f1_state_done", 32'(dut.state), 32'd3);
    tick();
    check_val("f1_hold_class", 32'(class_id), 32'd1);
    ack();
    check_val("f1_ack_valid", 32'(class_valid), 32'd0);
    check_val("f1_ack_idle", 32'(dut.state), 32'd0);

    // Closed-eye streak
    pixels(4); beat(32'sd9); beat(-32'sd3); check_result("s1", 0, 1, 0, 2); ack();
    pixels(4); beat(32'sd9); beat(-32'sd3); check_result("s2", 0, 2, 0, 3); ack();
    pixels(4); beat(32'sd9); beat(-32'sd3); check_result("s3", 0, 3, 1, 4); ack();
    pixels(4); beat(-32'sd1); beat(32'sd4); check_result("s4", 1, 0, 0, 5); ack();

    // Tie goes to lower index
    pixels(3); beat(32'sd2); beat(32'sd2); check_result("tie", 0, 1, 0, 6); ack();

    // Timeout: no logits after pixels end
    pixels(3);
    pulses = 0; first_k = 0;
    for (int k = 1; k <= T + 5; k++) begin
      tick();
      if (frame_timeout) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    check_val("to_pulses", 32'(pulses), 32'd1);
    check_val("to_cycle", 32'(first_k), 32'(T));
    check_val("to_streak", 32'(close_streak), 32'd0);
    check_val("to_state", 32'(dut.state), 32'd0);
    check_val("to_count", 32'(frame_count), 32'd6);
    check_val("to_valid", 32'(class_valid), 32'd0);

    // Last beat coincides with the timeout edge: beat wins
    pixels(3);
    beat(32'sd3);
    repeat (T - 2) tick();
    beat(32'sd1);
    check_val("race_no_pulse", 32'(frame_timeout), 32'd0);
    check_result("race", 0, 1, 0, 7);
    ack();
    check_val("perr_clean", 32'(protocol_err), 32'd0);

    // Stray beat in IDLE, then new frame while result is held
    beat(32'sd11);
    check_val("perr_set", 32'(protocol_err), 32'd1);
    tick(); tick();
    check_val("perr_sticky", 32'(protocol_err), 32'd1);
    pixels(3); beat(32'sd1); beat(32'sd5); check_result("pe", 1, 0, 0, 8);
    valid_in = 1'b1;
    tick();
    check_val("pe_drop_valid", 32'(class_valid), 32'd0);
    check_val("pe_state_load", 32'(dut.state), 32'd1);

    // Reset in WAIT after one beat
    valid_in = 1'b0;
    tick();
    beat(32'sd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_perr", 32'(protocol_err), 32'd0);
    check_val("arst_count", 32'(frame_count), 32'd0);
    check_val("arst_state", 32'(dut.state), 32'd0);
    check_val("arst_idx", 32'(dut.beat_idx), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    pixels(5); beat(-32'sd5); beat(32'sd7); check_result("post_rst", 1, 0, 0, 1);

    // Ack and new frame on the same edge
    result_ack = 1'b1; valid_in = 1'b1;
    tick();
    result_ack = 1'b0;
    check_val("ackrise_valid", 32'(class_valid), 32'd0);
    check_val("ackrise_state", 32'(dut.state), 32'd1);
    check_val("ackrise_perr", 32'(protocol_err), 32'd0);
    valid_in = 1'b0;
    tick();
    beat(32'sd9); beat(-32'sd3); check_result("ackrise_frame", 0, 1, 0, 2);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
